// File: rtl/encrypt_sequencer_pkg.sv
// Shared types and default constants for the LWE encrypt sequencer slice.
// Holds the FSM state enum, the row-index width and the default noise LFSR polynomial/seed.
package encrypt_sequencer_pkg;

    localparam int DEF_PLAINTEXT_WIDTH  = 6;
    localparam int DEF_CIPHERTEXT_WIDTH = 10;
    localparam int DEF_DIMENSION        = 10;
    localparam int DEF_BIG_N            = 30;

    // Row index width: rows run 0..DIMENSION inclusive.
    localparam int ROW_W = DEF_DIMENSION + 1;

    // x^30 + x^6 + x^4 + x + 1, Fibonacci form; the seed must never be zero.
    localparam logic [DEF_BIG_N-1:0] DEF_LFSR_TAPS = 30'h20000029;
    localparam logic [DEF_BIG_N-1:0] DEF_LFSR_SEED = 30'h1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_CAPT = 2'd2,
        ST_OUT  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/encrypt_sequencer_noise_lfsr.sv
// Fibonacci LFSR supplying the per-transaction noise_select vector.
// A reseed request beats a step in the same cycle; a zero seed falls back to LFSR_SEED.
module noise_lfsr #(
    parameter int               BIG_N     = 30,
    parameter logic [BIG_N-1:0] LFSR_TAPS = 30'h20000029,
    parameter logic [BIG_N-1:0] LFSR_SEED = 30'h1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             load,
    input  logic [BIG_N-1:0] load_value,
    output logic [BIG_N-1:0] state
);

    logic fb;

    assign fb = ^(state & LFSR_TAPS);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LFSR_SEED;
        end else if (load) begin
            // An all-zero state would lock the register up, so substitute the seed.
            state <= (load_value == '0) ? LFSR_SEED : load_value;
        end else if (step) begin
            state <= {state[BIG_N-2:0], fb};
        end
    end

endmodule

// File: rtl/encrypt_sequencer.sv
// Control stage ahead of the LWE encrypt datapath: walks rows 0..DIMENSION per plaintext,
// issues one public-key read per row and streams the captured partial ciphertext words.
module encrypt_sequencer
    import encrypt_sequencer_pkg::*;
#(
    parameter int               PLAINTEXT_WIDTH  = DEF_PLAINTEXT_WIDTH,
    parameter int               CIPHERTEXT_WIDTH = DEF_CIPHERTEXT_WIDTH,
    parameter int               DIMENSION        = DEF_DIMENSION,
    parameter int               BIG_N            = DEF_BIG_N,
    parameter logic [BIG_N-1:0] LFSR_TAPS        = DEF_LFSR_TAPS,
    parameter logic [BIG_N-1:0] LFSR_SEED        = DEF_LFSR_SEED
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pt_valid,
    output logic                        pt_ready,
    input  logic [PLAINTEXT_WIDTH-1:0]  pt_data,
    input  logic                        seed_load,
    input  logic [BIG_N-1:0]            seed_value,
    output logic                        pk_rd_en,
    output logic [DIMENSION:0]          pk_rd_addr,
    output logic [PLAINTEXT_WIDTH-1:0]  enc_plaintext,
    output logic [BIG_N-1:0]            enc_noise_select,
    output logic [DIMENSION:0]          enc_row,
    input  logic [CIPHERTEXT_WIDTH-1:0] enc_ciphertext,
    output logic                        ct_valid,
    input  logic                        ct_ready,
    output logic [CIPHERTEXT_WIDTH-1:0] ct_data,
    output logic [DIMENSION:0]          ct_index,
    output logic                        ct_last,
    output logic                        busy
);

    localparam int RW = DIMENSION + 1;

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] READ = ST_READ;
    localparam logic [1:0] CAPT = ST_CAPT;
    localparam logic [1:0] OUT  = ST_OUT;

    logic [1:0]       state;
    logic [RW-1:0]    row_cnt;
    logic [BIG_N-1:0] lfsr_state;
    logic             accept;
    logic             seed_take;

    assign accept    = (state == IDLE) && pt_valid;
    assign seed_take = (state == IDLE) && seed_load;

    noise_lfsr #(
        .BIG_N    (BIG_N),
        .LFSR_TAPS(LFSR_TAPS),
        .LFSR_SEED(LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .step      (accept),
        .load      (seed_take),
        .load_value(seed_value),
        .state     (lfsr_state)
    );

    assign pt_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign pk_rd_en   = (state == READ);
    assign pk_rd_addr = row_cnt;
    assign enc_row    = row_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            row_cnt          <= '0;
            enc_plaintext    <= '0;
            enc_noise_select <= '0;
            ct_valid         <= 1'b0;
            ct_data          <= '0;
            ct_index         <= '0;
            ct_last          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pt_valid) begin
                        // Noise vector is the LFSR value before this accept advances it.
                        enc_plaintext    <= pt_data;
                        enc_noise_select <= lfsr_state;
                        row_cnt          <= '0;
                        state            <= READ;
                    end
                end
                READ: state <= CAPT;
                CAPT: begin
                    // Memory data, and hence the datapath result, is valid one cycle after the read.
                    ct_data  <= enc_ciphertext;
                    ct_index <= row_cnt;
                    ct_last  <= (row_cnt == RW'(DIMENSION));
                    ct_valid <= 1'b1;
                    state    <= OUT;
                end
                OUT: begin
                    if (ct_ready) begin
                        ct_valid <= 1'b0;
                        if (ct_last) begin
                            state <= IDLE;
                        end else begin
                            row_cnt <= row_cnt + RW'(1);
                            state   <= READ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encrypt_sequencer.sv
// Self-checking bench for encrypt_sequencer: public-key memory and LWE datapath models,
// a transaction-level scoreboard checked every cycle, directed scenarios and a random phase.
module tb_encrypt_sequencer;
    import encrypt_sequencer_pkg::*;

    localparam int PW  = DEF_PLAINTEXT_WIDTH;
    localparam int CW  = DEF_CIPHERTEXT_WIDTH;
    localparam int DIM = DEF_DIMENSION;
    localparam int N   = DEF_BIG_N;
    localparam int RW  = ROW_W;
    localparam logic [N-1:0] TAPS = 30'h20000029;
    localparam logic [N-1:0] SEED = 30'h1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pt_valid = 1'b0;
    logic          pt_ready;
    logic [PW-1:0] pt_data = '0;
    logic          seed_load = 1'b0;
    logic [N-1:0]  seed_value = '0;
    logic          pk_rd_en;
    logic [RW-1:0] pk_rd_addr;
    logic [PW-1:0] enc_plaintext;
    logic [N-1:0]  enc_noise_select;
    logic [RW-1:0] enc_row;
    logic [CW-1:0] enc_ciphertext;
    logic          ct_valid;
    logic          ct_ready = 1'b1;
    logic [CW-1:0] ct_data;
    logic [RW-1:0] ct_index;
    logic          ct_last;
    logic          busy;

    encrypt_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .pt_valid        (pt_valid),
        .pt_ready        (pt_ready),
        .pt_data         (pt_data),
        .seed_load       (seed_load),
        .seed_value      (seed_value),
        .pk_rd_en        (pk_rd_en),
        .pk_rd_addr      (pk_rd_addr),
        .enc_plaintext   (enc_plaintext),
        .enc_noise_select(enc_noise_select),
        .enc_row         (enc_row),
        .enc_ciphertext  (enc_ciphertext),
        .ct_valid        (ct_valid),
        .ct_ready        (ct_ready),
        .ct_data         (ct_data),
        .ct_index        (ct_index),
        .ct_last         (ct_last),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Public-key table: pk[row][i] is the row-th element of public-key sample i.
    logic [CW-1:0] pk [0:DIM][0:N-1];

    function automatic logic [CW-1:0] lwe_word(input int r, input logic [N-1:0] ns, input logic [PW-1:0] pt);
        logic [CW-1:0] acc;
        acc = '0;
        for (int i = 0; i < N; i++)
            if (ns[i]) acc = acc + pk[r][i];
        if (r == DIM) acc = acc + {pt, {(CW-PW){1'b0}}};
        return acc;
    endfunction

    function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] v);
        return {v[N-2:0], ^(v & TAPS)};
    endfunction

    // Memory with one-cycle read latency feeding a combinational datapath.
    int mem_row_q = 0;
    always @(posedge clk)
        if (pk_rd_en) mem_row_q <= (int'(pk_rd_addr) <= DIM) ? int'(pk_rd_addr) : 0;

    always_comb enc_ciphertext = lwe_word(mem_row_q, enc_noise_select, enc_plaintext);

    // Transaction-level reference model and per-cycle comparison.
    typedef struct {
        logic [CW-1:0] data;
        int            index;
        bit            last;
    } exp_t;

    exp_t          exp_q[$];
    bit            m_init = 1'b0;
    bit            m_idle = 1'b1;
    logic [N-1:0]  m_lfsr = SEED;
    logic [N-1:0]  m_noise = '0;
    logic [PW-1:0] m_pt = '0;
    int            m_next_read = 0;
    int            m_txn = 0;

    always @(negedge clk) begin
        bit acc;
        bit old_idle;
        bit was_last;
        if (m_init) begin
            check("pt_ready", pt_ready, m_idle);
            check("busy", busy, !m_idle);
            if (m_idle) begin
                check("idle_quiet", {ct_valid, pk_rd_en}, 2'b00);
            end else begin
                check("enc_noise_select", enc_noise_select, m_noise);
                check("enc_plaintext", enc_plaintext, m_pt);
            end
            if (ct_valid) begin
                if (exp_q.size() == 0) begin
                    fail("ct_valid_unexpected");
                end else begin
                    check("ct_data", ct_data, exp_q[0].data);
                    check("ct_index", ct_index, exp_q[0].index);
                    check("ct_last", ct_last, exp_q[0].last);
                    check("enc_row_out", enc_row, exp_q[0].index);
                end
            end
            if (pk_rd_en) begin
                check("pk_rd_addr", pk_rd_addr, m_next_read);
                check("rd_while_valid", ct_valid, 1'b0);
            end
        end
        if (rst) begin
            m_init      = 1'b1;
            m_idle      = 1'b1;
            m_lfsr      = SEED;
            m_noise     = '0;
            m_pt        = '0;
            m_next_read = 0;
            exp_q.delete();
        end else if (m_init) begin
            old_idle = m_idle;
            acc      = old_idle && pt_valid;
            if (pk_rd_en) m_next_read++;
            if (ct_valid && ct_ready && exp_q.size() > 0) begin
                was_last = exp_q[0].last;
                void'(exp_q.pop_front());
                if (was_last) begin
                    check("reads_per_txn", m_next_read, RW);
                    m_idle = 1'b1;
                end
            end
            if (acc) begin
                m_pt        = pt_data;
                m_noise     = m_lfsr;
                m_next_read = 0;
                m_idle      = 1'b0;
                m_txn++;
                for (int r = 0; r <= DIM; r++)
                    exp_q.push_back('{data: lwe_word(r, m_lfsr, pt_data), index: r, last: (r == DIM)});
            end
            if (old_idle && seed_load) m_lfsr = (seed_value == '0) ? SEED : seed_value;
            else if (acc)              m_lfsr = lfsr_next(m_lfsr);
        end
    end

    // Stimulus: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PW-1:0] d);
        pt_data  = d;
        pt_valid = 1'b1;
        tick();
        pt_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!pt_ready && n < budget) begin
            tick();
            n++;
        end
        if (!pt_ready) fail("wait_idle_timeout");
    endtask

    task automatic wait_ct(input int idx, input int budget);
        int n;
        n = 0;
        while (!(ct_valid && int'(ct_index) == idx) && n < budget) begin
            tick();
            n++;
        end
        if (!(ct_valid && int'(ct_index) == idx)) fail($sformatf("wait_ct_%0d_timeout", idx));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen0;
        bit seen10;

        for (int r = 0; r <= DIM; r++)
            for (int i = 0; i < N; i++)
                pk[r][i] = CW'($urandom);
        pk[0][0]   = 10'd3;
        pk[DIM][0] = 10'd10;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_pt_ready", pt_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ct_valid", ct_valid, 1'b0);
        check("rst_ct_data", ct_data, '0);
        check("rst_ct_index", ct_index, '0);
        check("rst_ct_last", ct_last, 1'b0);
        check("rst_enc_row", enc_row, '0);
        check("rst_pk_rd", {pk_rd_en, pk_rd_addr}, '0);
        check("rst_enc_pt_ns", {enc_plaintext, enc_noise_select}, '0);
        check("rst_lfsr", dut.u_lfsr.state, 30'h1);

        // Single transaction, stray pt_valid while busy, fixed latency
        tick();
        ct_ready = 1'b1;
        send(6'd5);
        check("txn1_noise", enc_noise_select, 30'h1);
        n = 0;
        seen0 = 1'b0;
        seen10 = 1'b0;
        while (!pt_ready && n < 100) begin
            pt_valid = (n >= 5 && n < 10);
            pt_data  = 6'd7;
            tick();
            n++;
            if (ct_valid && ct_index == 0) begin
                check("txn1_word0", ct_data, 10'd3);
                seen0 = 1'b1;
            end
            if (ct_valid && ct_index == RW'(DIM)) begin
                check("txn1_word10", ct_data, 10'd90);
                check("txn1_last", ct_last, 1'b1);
                seen10 = 1'b1;
            end
        end
        pt_valid = 1'b0;
        check("txn1_cycles", n, 33);
        if (!seen0 || !seen10) fail("txn1_words_not_seen");

        // Back-to-back accept
        send(6'd63);
        check("txn2_noise", enc_noise_select, 30'h3);
        wait_idle(200);

        // Backpressure at index 4
        send(6'($urandom));
        wait_ct(4, 50);
        ct_ready = 1'b0;
        repeat (5) tick();
        check("bp_hold_valid", ct_valid, 1'b1);
        check("bp_hold_index", ct_index, 4);
        ct_ready = 1'b1;
        tick();
        wait_ct(5, 10);
        wait_idle(200);

        // Seeding
        seed_value = 30'h12345;
        seed_load  = 1'b1;
        tick();
        seed_load  = 1'b0;
        send(6'd9);
        check("seed_noise", enc_noise_select, 30'h12345);
        wait_idle(200);
        seed_value = '0;
        seed_load  = 1'b1;
        tick();
        seed_load  = 1'b0;
        send(6'd1);
        check("seed_zero_noise", enc_noise_select, 30'h1);
        repeat (3) tick();
        seed_value = 30'h777;
        seed_load  = 1'b1;
        repeat (3) tick();
        seed_load  = 1'b0;
        wait_idle(200);
        send(6'd2);
        check("seed_busy_ignored", enc_noise_select, 30'h3);
        wait_idle(200);

        // Reset in the middle of a transaction
        send(6'd4);
        wait_ct(6, 50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_pt_ready", pt_ready, 1'b1);
        check("midrst_ct_valid", ct_valid, 1'b0);
        send(6'd11);
        check("midrst_noise", enc_noise_select, 30'h1);
        check("midrst_first_read", {pk_rd_en, pk_rd_addr}, {1'b1, RW'(0)});
        wait_idle(200);

        // Random traffic
        for (int c = 0; c < 2500; c++) begin
            ct_ready   = ($urandom_range(3) != 0);
            pt_valid   = ($urandom_range(2) == 0);
            pt_data    = PW'($urandom);
            seed_load  = ($urandom_range(15) == 0);
            seed_value = ($urandom_range(3) == 0) ? '0 : N'($urandom);
            rst        = ($urandom_range(399) == 0);
            tick();
        end
        rst       = 1'b0;
        pt_valid  = 1'b0;
        seed_load = 1'b0;
        ct_ready  = 1'b1;
        tick();
        wait_idle(200);
        check("random_txn_activity", (m_txn > 20), 1'b1);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
